// File: rtl/eeprom_write_sequencer_if.sv
// Bundle between the EEPROM write sequencer, its requester and the downstream
// task_controller bit-slot stage.
interface eeprom_write_sequencer_if;
    // Requester side: start is a one-shot request, honoured only while the
    // sequencer idles; busy/finished/error report progress.
    // Slot side: four-phase en/done handshake. task_en rises with task_com
    // stable, is held until task_done rises, then falls. The next slot
    // starts only after task_done has fallen again.
    logic        start;
    logic [15:0] mem_addr;
    logic [7:0]  wr_data;
    logic        busy;
    logic        finished;
    logic        error;
    logic [1:0]  task_com;
    logic        task_en;
    logic        task_done;

    modport master (
        output start, mem_addr, wr_data, task_done,
        input  busy, finished, error, task_com, task_en
    );

    modport slave (
        input  start, mem_addr, wr_data, task_done,
        output busy, finished, error, task_com, task_en
    );
endinterface

// File: rtl/eeprom_write_sequencer.sv
// Frames one I2C EEPROM byte write (START, control, address, data, ACK slots,
// STOP) as bit-slot commands for the downstream task_controller.
module eeprom_write_sequencer #(
    parameter logic [6:0] DEV_ADDR   = 7'h50,
    parameter int         ADDR_BYTES = 1,
    parameter logic [7:0] TIMEOUT    = 8'd255
) (
    input  logic                           clk,
    input  logic                           rst,
    eeprom_write_sequencer_if.slave        bus,
    output logic [2:0]                     dbg_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT_HI = 3'd2,
        WAIT_LO = 3'd3,
        FINISH  = 3'd4,
        ABORT   = 3'd5
    } state_t;

    localparam logic [1:0] COM_BIT0  = 2'b00;
    localparam logic [1:0] COM_BIT1  = 2'b11;
    localparam logic [1:0] COM_START = 2'b10;
    localparam logic [1:0] COM_STOP  = 2'b01;

    // START + (control, address, data bytes) * (8 bits + ACK), STOP last
    localparam int         LAST_INT  = 1 + 9 * (2 + ADDR_BYTES);
    localparam logic [5:0] LAST_SLOT = LAST_INT[5:0];

    state_t      state_q, state_d;
    logic [5:0]  slot_q, slot_d;
    logic [3:0]  bit_q, bit_d;
    logic [2:0]  byte_q, byte_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  timer_q, timer_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic [1:0]  com_q, com_d;
    logic        busy_q, fin_q, err_q, en_q;
    logic        busy_d, fin_d, err_d, en_d;

    logic [2:0]  nb_idx;
    logic [7:0]  next_byte;
    logic [1:0]  slot_com;

    assign nb_idx = byte_q + 3'd1;

    // Byte order on the wire: control, address (MSB byte first), data
    always_comb begin
        next_byte = 8'h00;
        if (ADDR_BYTES == 2) begin
            case (nb_idx)
                3'd1:    next_byte = addr_q[15:8];
                3'd2:    next_byte = addr_q[7:0];
                3'd3:    next_byte = data_q;
                default: next_byte = 8'h00;
            endcase
        end else begin
            case (nb_idx)
                3'd1:    next_byte = addr_q[7:0];
                3'd2:    next_byte = data_q;
                default: next_byte = 8'h00;
            endcase
        end
    end

    // ACK slots release SDA (11); nothing is sampled back
    always_comb begin
        slot_com = COM_BIT0;
        if (slot_q == 6'd0)
            slot_com = COM_START;
        else if (slot_q == LAST_SLOT)
            slot_com = COM_STOP;
        else if (bit_q == 4'd8)
            slot_com = COM_BIT1;
        else
            slot_com = shift_q[7] ? COM_BIT1 : COM_BIT0;
    end

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shift_d = shift_q;
        timer_d = timer_q;
        addr_d  = addr_q;
        data_d  = data_q;
        com_d   = com_q;

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.task_done) begin
                    addr_d  = bus.mem_addr;
                    data_d  = bus.wr_data;
                    slot_d  = 6'd0;
                    bit_d   = 4'd0;
                    byte_d  = 3'd0;
                    shift_d = {DEV_ADDR, 1'b0};
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                com_d   = slot_com;
                timer_d = 8'd0;
                state_d = WAIT_HI;
            end
            WAIT_HI: begin
                // A done edge on the timeout cycle takes priority
                if (bus.task_done)
                    state_d = WAIT_LO;
                else if (timer_q == TIMEOUT)
                    state_d = ABORT;
                else
                    timer_d = timer_q + 8'd1;
            end
            WAIT_LO: begin
                if (!bus.task_done) begin
                    if (slot_q == LAST_SLOT) begin
                        state_d = FINISH;
                    end else begin
                        slot_d  = slot_q + 6'd1;
                        state_d = ISSUE;
                        if (slot_q != 6'd0) begin
                            if (bit_q == 4'd8) begin
                                bit_d   = 4'd0;
                                byte_d  = nb_idx;
                                shift_d = next_byte;
                            end else begin
                                bit_d   = bit_q + 4'd1;
                                shift_d = {shift_q[6:0], 1'b0};
                            end
                        end
                    end
                end else if (timer_q == TIMEOUT) begin
                    state_d = ABORT;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            FINISH:  state_d = IDLE;
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered decodes of the state being entered
        busy_d = (state_d == ISSUE) || (state_d == WAIT_HI) || (state_d == WAIT_LO);
        en_d   = (state_d == WAIT_HI);
        fin_d  = (state_d == FINISH);
        err_d  = (state_d == ABORT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            slot_q  <= 6'd0;
            bit_q   <= 4'd0;
            byte_q  <= 3'd0;
            shift_q <= 8'h00;
            timer_q <= 8'd0;
            addr_q  <= 16'h0000;
            data_q  <= 8'h00;
            com_q   <= COM_BIT0;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
            err_q   <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            shift_q <= shift_d;
            timer_q <= timer_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            com_q   <= com_d;
            busy_q  <= busy_d;
            fin_q   <= fin_d;
            err_q   <= err_d;
            en_q    <= en_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.finished = fin_q;
    assign bus.error    = err_q;
    assign bus.task_en  = en_q;
    assign bus.task_com = com_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_eeprom_write_sequencer.sv
// Bench for eeprom_write_sequencer: two instances (1 and 2 address bytes)
// driven by a task_controller model, slot streams scored against vectors.
module tb_eeprom_write_sequencer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    eeprom_write_sequencer_if ia();
    eeprom_write_sequencer_if ib();
    logic [2:0] dbg_a, dbg_b;

    eeprom_write_sequencer #(.DEV_ADDR(7'h50), .ADDR_BYTES(1), .TIMEOUT(8'd20)) dut_a (
        .clk(clk), .rst(rst), .bus(ia), .dbg_state(dbg_a)
    );
    eeprom_write_sequencer #(.DEV_ADDR(7'h50), .ADDR_BYTES(2), .TIMEOUT(8'd20)) dut_b (
        .clk(clk), .rst(rst), .bus(ib), .dbg_state(dbg_b)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [1:0] exp_q[$];
    logic [1:0] got_a[$];
    logic [1:0] got_b[$];

    // spec vector: DEV 50, addr 3C, data A5
    logic [1:0] t1 [29] = '{
        2'b10,
        2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11,
        2'b00, 2'b00, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b11,
        2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b11, 2'b11,
        2'b01
    };

    int   mode_a = 0, mode_b = 0;  // 0 normal, 1 never done, 2 done stuck high
    int   cnt_a = 0, cnt_b = 0;
    int   fin_a = 0, err_a = 0, fin_b = 0, err_b = 0, busy_rise_a = 0;
    int   com_viol = 0;
    int   t_en_a = 0, t_err_a = 0;
    logic err_busy_a = 1'b1, err_en_a = 1'b1;
    logic prev_en_a = 1'b0, prev_en_b = 1'b0, prev_busy_a = 1'b0;
    logic [1:0] prev_com_a = 2'b00, prev_com_b = 2'b00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_step(input logic en, input int mode, inout int cnt, inout logic done);
        if (mode == 2) begin
            done = 1'b1;
        end else if (mode == 1) begin
            done = 1'b0;
        end else if (en) begin
            if (!done) begin
                cnt++;
                if (cnt >= 6) done = 1'b1;
            end
        end else begin
            cnt  = 0;
            done = 1'b0;
        end
    endtask

    // ---------------- monitor + task_controller model ----------------
    initial begin
        logic d;
        ia.task_done = 1'b0;
        ib.task_done = 1'b0;
        forever begin
            @(negedge clk);
            if (ia.task_en && !prev_en_a) begin
                got_a.push_back(ia.task_com);
                t_en_a = cyc;
            end
            if (ia.task_en && prev_en_a && ia.task_com != prev_com_a) com_viol++;
            if (ib.task_en && !prev_en_b) got_b.push_back(ib.task_com);
            if (ib.task_en && prev_en_b && ib.task_com != prev_com_b) com_viol++;
            if (ia.finished) fin_a++;
            if (ib.finished) fin_b++;
            if (ia.error) begin
                err_a++;
                t_err_a    = cyc;
                err_busy_a = ia.busy;
                err_en_a   = ia.task_en;
            end
            if (ib.error) err_b++;
            if (ia.busy && !prev_busy_a) busy_rise_a++;
            prev_en_a   = ia.task_en;
            prev_en_b   = ib.task_en;
            prev_com_a  = ia.task_com;
            prev_com_b  = ib.task_com;
            prev_busy_a = ia.busy;
            d = ia.task_done;
            model_step(ia.task_en, mode_a, cnt_a, d);
            ia.task_done = d;
            d = ib.task_done;
            model_step(ib.task_en, mode_b, cnt_b, d);
            ib.task_done = d;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_frame(input bit sel, input logic [15:0] addr, input logic [7:0] data,
                             output bit ok);
        int base;
        base = sel ? (fin_b + err_b) : (fin_a + err_a);
        @(negedge clk);
        if (sel) begin ib.mem_addr = addr; ib.wr_data = data; ib.start = 1'b1; end
        else     begin ia.mem_addr = addr; ia.wr_data = data; ia.start = 1'b1; end
        @(negedge clk);
        ia.start = 1'b0;
        ib.start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk); #2;
            if ((sel ? (fin_b + err_b) : (fin_a + err_a)) > base) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) exp_q.push_back(b[i] ? 2'b11 : 2'b00);
        exp_q.push_back(2'b11);
    endtask

    task automatic score(input string tag, input bit sel);
        logic [1:0] g;
        int n;
        n = sel ? got_b.size() : got_a.size();
        check({tag, "_len"}, n, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            g = 2'bxx;
            if (i < n) g = sel ? got_b[i] : got_a[i];
            check($sformatf("%s_slot%0d", tag, i), g, exp_q[i]);
        end
        exp_q.delete();
        got_a.delete();
        got_b.delete();
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit ok;
        int f0, e0, b0, n;
        ia.start = 1'b0; ia.mem_addr = 16'h0; ia.wr_data = 8'h0;
        ib.start = 1'b0; ib.mem_addr = 16'h0; ib.wr_data = 8'h0;
        rst = 1'b1;
        wait_cycles(3);
        rst = 1'b0;
        #1;
        check("rst_busy", ia.busy, 1'b0);
        check("rst_finished", ia.finished, 1'b0);
        check("rst_error", ia.error, 1'b0);
        check("rst_task_en", ia.task_en, 1'b0);
        check("rst_task_com", ia.task_com, 2'b00);
        check("rst_state", dbg_a, 3'd0);
        check("rst_b_task_en", ib.task_en, 1'b0);

        // 1: single-byte address frame
        for (int i = 0; i < 29; i++) exp_q.push_back(t1[i]);
        run_frame(1'b0, 16'h003C, 8'hA5, ok);
        check("t1_done", ok, 1'b1);
        check("t1_fin", fin_a, 1);
        check("t1_err", err_a, 0);
        score("t1", 1'b0);

        // 2: two-byte address frame
        exp_q.push_back(2'b10);
        push_byte(8'hA0);
        push_byte(8'h12);
        push_byte(8'h34);
        push_byte(8'h00);
        exp_q.push_back(2'b01);
        run_frame(1'b1, 16'h1234, 8'h00, ok);
        check("t2_done", ok, 1'b1);
        check("t2_fin", fin_b, 1);
        check("t2_err", err_b, 0);
        check("t2_last_com", ib.task_com, 2'b01);
        score("t2", 1'b1);

        // 3: start held high, three back-to-back frames
        f0 = fin_a; e0 = err_a; b0 = busy_rise_a;
        for (int r = 0; r < 3; r++) for (int i = 0; i < 29; i++) exp_q.push_back(t1[i]);
        @(negedge clk);
        ia.mem_addr = 16'h003C; ia.wr_data = 8'hA5; ia.start = 1'b1;
        n = 0;
        for (int i = 0; i < 5000 && n < 3; i++) begin
            @(negedge clk);
            if (ia.finished) n++;
        end
        ia.start = 1'b0;
        wait_cycles(5);
        check("t3_frames", n, 3);
        check("t3_busy_rises", busy_rise_a - b0, 3);
        check("t3_fin", fin_a - f0, 3);
        check("t3_err", err_a - e0, 0);
        check("t3_idle_busy", ia.busy, 1'b0);
        score("t3", 1'b0);

        // 4: downstream never answers
        mode_a = 1;
        f0 = fin_a; e0 = err_a;
        run_frame(1'b0, 16'h0001, 8'h5A, ok);
        check("t4_done", ok, 1'b1);
        check("t4_err_cnt", err_a - e0, 1);
        check("t4_fin_cnt", fin_a - f0, 0);
        check("t4_latency", t_err_a - t_en_a, 21);
        check("t4_err_busy", err_busy_a, 1'b0);
        check("t4_err_en", err_en_a, 1'b0);
        check("t4_pulse_end", ia.error, 1'b0);
        mode_a = 0;
        got_a.delete();
        wait_cycles(3);

        // 5: reset in the middle of slot 12
        f0 = fin_a; e0 = err_a;
        @(negedge clk);
        ia.mem_addr = 16'h003C; ia.wr_data = 8'hA5; ia.start = 1'b1;
        @(negedge clk);
        ia.start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #2;
            if (got_a.size() >= 13) begin ok = 1'b1; break; end
        end
        check("t5_reach_slot12", ok, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("t5_rst_en", ia.task_en, 1'b0);
        check("t5_rst_busy", ia.busy, 1'b0);
        wait_cycles(2);
        rst = 1'b0;
        wait_cycles(3);
        check("t5_no_fin", fin_a - f0, 0);
        check("t5_no_err", err_a - e0, 0);
        check("t5_done_low", ia.task_done, 1'b0);
        got_a.delete();
        for (int i = 0; i < 29; i++) exp_q.push_back(t1[i]);
        run_frame(1'b0, 16'h003C, 8'hA5, ok);
        check("t5_done", ok, 1'b1);
        check("t5_fin", fin_a - f0, 1);
        score("t5", 1'b0);

        // 6: start while task_done is stuck high
        b0 = busy_rise_a;
        mode_a = 2;
        wait_cycles(2);
        @(negedge clk);
        ia.start = 1'b1;
        wait_cycles(6);
        check("t6_busy", ia.busy, 1'b0);
        check("t6_en", ia.task_en, 1'b0);
        check("t6_state", dbg_a, 3'd0);
        check("t6_busy_rises", busy_rise_a - b0, 0);
        @(negedge clk);
        ia.start = 1'b0;
        mode_a = 0;
        wait_cycles(3);
        check("t6_done_low", ia.task_done, 1'b0);

        check("com_stable", com_viol, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
